// File: rtl/mm2_load_resp.sv
// rtl/mm2_load_resp.sv - MM2 load-response wait, data alignment and writeback register
module mm2_load_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        mm2_valid,
    input  logic        mm2_mm_re,
    input  logic [1:0]  mm2_mm_access_sz,
    input  logic [1:0]  mm2_mm_addr_l,
    input  logic        mm2_ld_unsigned,
    input  logic [31:0] mm2_exe_out,
    input  logic [4:0]  mm2_reg_d,
    input  logic        mm2_reg_d_wen,
    input  logic [31:0] mm2_pc,
    input  logic        dm_rdata_valid,
    input  logic [31:0] dm_rdata,
    input  logic        wb_allowin,
    output logic        mm2_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg_d,
    output logic        wb_reg_d_wen,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_reg_d_q, wb_reg_d_d;
    logic        wb_reg_d_wen_q, wb_reg_d_wen_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [31:0] wb_pc_q, wb_pc_d;

    logic        out_free;
    logic        retire;
    logic [31:0] ld_src;
    logic [31:0] ret_data;

    // Select the addressed byte/half of a read word and extend it to 32 bits.
    function automatic logic [31:0] align_load(input logic [31:0] d,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  addr_l,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_l)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        // addr_l[0] is ignored for halves; misaligned halves never reach here.
        h = addr_l[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Result selection: buffered data in FULL, live response otherwise, ALU result for non-loads.
    always_comb begin
        out_free = ~wb_valid_q | wb_allowin;
        ld_src   = (state_q == FULL) ? buf_q : dm_rdata;
        ret_data = mm2_mm_re ? align_load(ld_src, mm2_mm_access_sz, mm2_mm_addr_l, mm2_ld_unsigned)
                             : mm2_exe_out;
    end

    // Response-tracking FSM: decides when the instruction retires and what happens to responses.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mm2_valid) begin
                    if (!mm2_mm_re) begin
                        retire = ~flush & out_free;
                    end else if (dm_rdata_valid) begin
                        // A flushed load whose response is here simply drops it.
                        if (!flush) begin
                            if (out_free) begin
                                retire = 1'b1;
                            end else begin
                                buf_d   = dm_rdata;
                                state_d = FULL;
                            end
                        end
                    end else begin
                        state_d = flush ? DRAIN : WAIT;
                    end
                end
            end
            WAIT: begin
                if (dm_rdata_valid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (out_free) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        buf_d   = dm_rdata;
                        state_d = FULL;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            FULL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (out_free) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // The orphaned response of the flushed load is swallowed here.
                if (dm_rdata_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback bundle: load on retire, drop valid after a WB handshake.
    always_comb begin
        wb_valid_d     = wb_valid_q;
        wb_reg_d_d     = wb_reg_d_q;
        wb_reg_d_wen_d = wb_reg_d_wen_q;
        wb_wdata_d     = wb_wdata_q;
        wb_pc_d        = wb_pc_q;
        if (retire) begin
            wb_valid_d     = 1'b1;
            wb_reg_d_d     = mm2_reg_d;
            wb_reg_d_wen_d = mm2_reg_d_wen;
            wb_wdata_d     = ret_data;
            wb_pc_d        = mm2_pc;
        end else if (wb_allowin) begin
            wb_valid_d = 1'b0;
        end
    end

    // State, buffer and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            buf_q          <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_reg_d_q     <= 5'd0;
            wb_reg_d_wen_q <= 1'b0;
            wb_wdata_q     <= 32'd0;
            wb_pc_q        <= 32'd0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_d_q     <= wb_reg_d_d;
            wb_reg_d_wen_q <= wb_reg_d_wen_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_pc_q        <= wb_pc_d;
        end
    end

    assign mm2_stall    = (mm2_valid & ~retire) | (state_q == DRAIN);
    assign wb_valid     = wb_valid_q;
    assign wb_reg_d     = wb_reg_d_q;
    assign wb_reg_d_wen = wb_reg_d_wen_q;
    assign wb_wdata     = wb_wdata_q;
    assign wb_pc        = wb_pc_q;

endmodule

// File: tb/tb_mm2_load_resp.sv
// tb/tb_mm2_load_resp.sv - self-checking bench for mm2_load_resp
module tb_mm2_load_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        mm2_valid;
    logic        mm2_mm_re;
    logic [1:0]  mm2_mm_access_sz;
    logic [1:0]  mm2_mm_addr_l;
    logic        mm2_ld_unsigned;
    logic [31:0] mm2_exe_out;
    logic [4:0]  mm2_reg_d;
    logic        mm2_reg_d_wen;
    logic [31:0] mm2_pc;
    logic        dm_rdata_valid;
    logic [31:0] dm_rdata;
    logic        wb_allowin;
    logic        mm2_stall;
    logic        wb_valid;
    logic [4:0]  wb_reg_d;
    logic        wb_reg_d_wen;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;

    mm2_load_resp dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .mm2_valid        (mm2_valid),
        .mm2_mm_re        (mm2_mm_re),
        .mm2_mm_access_sz (mm2_mm_access_sz),
        .mm2_mm_addr_l    (mm2_mm_addr_l),
        .mm2_ld_unsigned  (mm2_ld_unsigned),
        .mm2_exe_out      (mm2_exe_out),
        .mm2_reg_d        (mm2_reg_d),
        .mm2_reg_d_wen    (mm2_reg_d_wen),
        .mm2_pc           (mm2_pc),
        .dm_rdata_valid   (dm_rdata_valid),
        .dm_rdata         (dm_rdata),
        .wb_allowin       (wb_allowin),
        .mm2_stall        (mm2_stall),
        .wb_valid         (wb_valid),
        .wb_reg_d         (wb_reg_d),
        .wb_reg_d_wen     (wb_reg_d_wen),
        .wb_wdata         (wb_wdata),
        .wb_pc            (wb_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: orphans still to swallow, data already held for the current instruction,
    // and the expected writeback bundle.
    int          m_drain;
    bit          m_have;
    logic [31:0] m_data;
    bit          e_valid;
    logic [4:0]  e_reg_d;
    bit          e_wen;
    logic [31:0] e_wdata;
    logic [31:0] e_pc;
    int          mem_owed;
    bit          last_stall;
    bit          last_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] a, input bit uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * a)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (a >= 2) ? (d / 65536) : (d % 65536);
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic put(input bit v, input bit re, input logic [1:0] sz, input logic [1:0] a,
                       input bit u, input logic [31:0] exe, input logic [31:0] pc);
        mm2_valid        = v;
        mm2_mm_re        = re;
        mm2_mm_access_sz = sz;
        mm2_mm_addr_l    = a;
        mm2_ld_unsigned  = u;
        mm2_exe_out      = exe;
        mm2_reg_d        = 5'($urandom);
        mm2_reg_d_wen    = 1'($urandom);
        mm2_pc           = pc;
        if (v && re) mem_owed++;
    endtask

    task automatic rsp(input bit v, input logic [31:0] d);
        dm_rdata_valid = v;
        dm_rdata       = d;
        if (v) mem_owed--;
    endtask

    task automatic model_reset();
        m_drain  = 0;
        m_have   = 0;
        m_data   = 0;
        e_valid  = 0;
        e_reg_d  = 0;
        e_wen    = 0;
        e_wdata  = 0;
        e_pc     = 0;
        mem_owed = 0;
        last_stall = 0;
        last_flush = 0;
    endtask

    // One clock: predict stall and retire from the rules, check stall, clock, check wb bundle.
    task automatic cycle();
        bit          free, retire, avail, draining, exp_stall;
        logic [31:0] val;
        #1;
        free     = !e_valid || wb_allowin;
        retire   = 0;
        draining = (m_drain > 0);
        val      = 0;
        if (draining) begin
            if (dm_rdata_valid) m_drain--;
        end else if (mm2_valid) begin
            if (mm2_mm_re)
                val = ref_load(m_have ? m_data : dm_rdata, mm2_mm_access_sz, mm2_mm_addr_l, mm2_ld_unsigned);
            else
                val = mm2_exe_out;
            avail = !mm2_mm_re || m_have || dm_rdata_valid;
            if (flush) begin
                if (!avail) m_drain = 1;
                m_have = 0;
            end else if (avail && free) begin
                retire = 1;
                m_have = 0;
            end else if (mm2_mm_re && dm_rdata_valid && !m_have) begin
                m_have = 1;
                m_data = dm_rdata;
            end
        end
        exp_stall = draining || (mm2_valid && !retire);
        chk("mm2_stall", 32'(mm2_stall), 32'(exp_stall));
        last_stall = exp_stall;
        last_flush = flush;
        if (retire) begin
            e_valid = 1;
            e_reg_d = mm2_reg_d;
            e_wen   = mm2_reg_d_wen;
            e_wdata = val;
            e_pc    = mm2_pc;
        end else if (e_valid && wb_allowin) begin
            e_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 32'(wb_valid), 32'(e_valid));
        chk("wb_reg_d", 32'(wb_reg_d), 32'(e_reg_d));
        chk("wb_reg_d_wen", 32'(wb_reg_d_wen), 32'(e_wen));
        chk("wb_wdata", wb_wdata, e_wdata);
        chk("wb_pc", wb_pc, e_pc);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_wb_reg_d", 32'(wb_reg_d), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wb_allowin = 1'b1;
        mem_owed = 0;
        put(0, 0, 0, 0, 0, 0, 0);
        rsp(0, 0);
        do_reset();

        // Non-load back to back.
        put(1, 0, 2, 0, 0, 32'h1234_5678, 32'h1c00_0000);
        cycle();
        chk("nl_wdata", wb_wdata, 32'h1234_5678);
        chk("nl_pc", wb_pc, 32'h1c00_0000);
        put(1, 0, 2, 0, 0, 32'h9abc_def0, 32'h1c00_0004);
        cycle();
        chk("nl2_wdata", wb_wdata, 32'h9abc_def0);

        // ld.b / ld.bu at addr_l=3 with two cycles of wait.
        put(1, 1, 0, 3, 0, 0, 32'h1c00_0010);
        cycle();
        cycle();
        rsp(1, 32'h80AA_BBCC);
        cycle();
        chk("ld_b", wb_wdata, 32'hFFFF_FF80);
        put(1, 1, 0, 3, 1, 0, 32'h1c00_0014);
        rsp(0, 0);
        cycle();
        cycle();
        rsp(1, 32'h80AA_BBCC);
        cycle();
        chk("ld_bu", wb_wdata, 32'h0000_0080);

        // ld.h at addr_l=2 and 0, response in the same cycle.
        put(1, 1, 1, 2, 0, 0, 32'h1c00_0018);
        rsp(1, 32'h8001_7FFF);
        cycle();
        chk("ld_h_hi", wb_wdata, 32'hFFFF_8001);
        put(1, 1, 1, 0, 0, 0, 32'h1c00_001c);
        rsp(1, 32'h8001_7FFF);
        cycle();
        chk("ld_h_lo", wb_wdata, 32'h0000_7FFF);

        // WB blocked while the response arrives: buffer, hold, then retire.
        put(1, 1, 2, 0, 0, 0, 32'h1c00_0020);
        wb_allowin = 1'b0;
        rsp(1, 32'hDEAD_BEEF);
        cycle();
        rsp(0, 0);
        cycle();
        cycle();
        wb_allowin = 1'b1;
        cycle();
        chk("full_wdata", wb_wdata, 32'hDEAD_BEEF);

        // Flush in WAIT; next load swallows nothing until the orphan drains.
        put(1, 1, 2, 0, 0, 0, 32'h1c00_0100);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        put(1, 1, 2, 0, 0, 0, 32'h1c00_0104);
        cycle();
        cycle();
        cycle();
        rsp(1, 32'h1111_1111);
        cycle();
        rsp(1, 32'h2222_2222);
        cycle();
        rsp(0, 0);
        chk("drain_pc", wb_pc, 32'h1c00_0104);
        chk("drain_wdata", wb_wdata, 32'h2222_2222);

        // Flush coincident with the response in WAIT.
        put(1, 1, 2, 0, 0, 0, 32'h1c00_0200);
        cycle();
        flush = 1'b1;
        rsp(1, 32'h3333_3333);
        cycle();
        flush = 1'b0;
        rsp(0, 0);
        put(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("flush_rsp_pc", wb_pc, 32'h1c00_0104);

        // Reset mid-WAIT with a valid bundle held; later response ignored.
        put(1, 0, 2, 0, 0, 32'h5555_5555, 32'h1c00_0300);
        cycle();
        wb_allowin = 1'b0;
        put(1, 1, 2, 0, 0, 0, 32'h1c00_0304);
        cycle();
        do_reset();
        put(0, 0, 0, 0, 0, 0, 0);
        wb_allowin = 1'b1;
        rsp(1, 32'h4444_4444);
        cycle();
        rsp(0, 0);
        put(1, 0, 2, 0, 0, 32'h6666_6666, 32'h1c00_0308);
        cycle();
        chk("post_rst_wdata", wb_wdata, 32'h6666_6666);

        // Randomized traffic against the model.
        put(0, 0, 0, 0, 0, 0, 0);
        cycle();
        mem_owed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall || last_flush)
                put(($urandom % 4) != 0, 1'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), $urandom, $urandom);
            flush = (m_drain == 0) && mm2_valid && (($urandom % 8) == 0);
            if (mem_owed > 0 && ($urandom % 3) == 0)
                rsp(1, $urandom);
            else
                rsp(0, 0);
            wb_allowin = ($urandom % 4) != 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm2_load_resp.md
Name: mm2_load_resp

Overview:
- MM2-stage consumer of the mm1→mm2 pipeline register and receiver of data-memory read responses.
- Waits for the load response the MM1 request is owed, then aligns and extends the read data.
- Produces a registered writeback bundle for the WB stage.
- Back-pressures MM1 through mm2_stall, handles WB back-pressure and flush, and drains orphaned responses after a flush.

Parameters:
- None. Widths are fixed by the LA32 datapath.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill instruction currently in MM2 (exception/ertn)
mm2_valid  in  1  MM2 holds a live instruction
mm2_mm_re  in  1  instruction is a load; one dm response is owed
mm2_mm_access_sz  in  2  00 byte, 01 half, 10 word, 11 treated as word
mm2_mm_addr_l  in  2  low address bits of load
mm2_ld_unsigned  in  1  1 = zero-extend (ld.bu/ld.hu)
mm2_exe_out  in  32  ALU/CSR result for non-loads
mm2_reg_d  in  5  destination register
mm2_reg_d_wen  in  1  destination write enable
mm2_pc  in  32  instruction PC
dm_rdata_valid  in  1  one-cycle pulse: read response present
dm_rdata  in  32  read response data
wb_allowin  in  1  WB accepts the bundle this cycle
mm2_stall  out  1  MM2 not retiring this cycle; MM1 must hold (drives mm1→mm2 wen low)
wb_valid  out  1  writeback bundle valid
wb_reg_d  out  5  registered mm2_reg_d
wb_reg_d_wen  out  1  registered mm2_reg_d_wen
wb_wdata  out  32  registered result
wb_pc  out  32  registered mm2_pc

Behaviour:
- Reset: asynchronous, active-low. State=IDLE. All wb_* outputs = 0. Data buffer = 0.
- Output availability: out_free = !wb_valid | wb_allowin.
- wb_valid falls after a handshake (wb_valid & wb_allowin) unless a new retire loads the same edge.
- Retire: loads wb_* registers on the edge. wb_valid = 1 on the cycle after retire. Retire requires !flush.
- mm2_stall = mm2_valid & !retire_this_cycle, or state==DRAIN.
- States: IDLE, WAIT, FULL, DRAIN.
- IDLE:
  - Non-load (mm2_valid, !mm2_mm_re): retire if out_free, with wdata = mm2_exe_out.
  - Load, dm_rdata_valid high: retire aligned data if out_free; else capture dm_rdata into buffer → FULL.
  - Load, dm_rdata_valid low → WAIT.
- WAIT:
  - dm_rdata_valid & out_free: retire aligned data → IDLE.
  - dm_rdata_valid & !out_free: buffer → FULL.
  - Otherwise stay.
- FULL: out_free → retire from buffer → IDLE.
- DRAIN: the first dm_rdata_valid is discarded → IDLE. mm2_stall held at 1 throughout.
- Flush, by state:
  - IDLE with an owed load not answered this cycle → DRAIN.
  - IDLE with the response present this cycle → drop it, stay IDLE.
  - WAIT → DRAIN; if dm_rdata_valid is high that same cycle → IDLE.
  - FULL → IDLE, buffer dropped.
  - DRAIN → unaffected.
  - Flush never retires and never clears an already-valid wb bundle.
- Alignment (extension by mm2_ld_unsigned):
  - Byte: dm_rdata >> (addr_l·8), take bits [7:0], then sign- or zero-extend.
  - Half: addr_l[1]=1 selects [31:16], else [15:0]; then extend. addr_l[0] is ignored (misalignment is trapped upstream).
  - Word / access_sz 11: dm_rdata unchanged.
- Input stability: in WAIT/FULL the mm2_* inputs are stable, because the stall holds the register. Alignment in FULL uses the current inputs with the buffered data.
- Exactly one response per load. A dm_rdata_valid in IDLE with no owed load is ignored.
- Reset mid-WAIT/DRAIN: return to IDLE; any later response is ignored.

Test Plan:
- Non-load back-to-back, wb_allowin=1, exe_out=0x1234_5678, pc=0x1c00_0000 → wb_valid the next cycle with wdata 0x12345678; mm2_stall never asserted.
- ld.b, addr_l=3, dm_rdata=0x80AA_BBCC with 2 cycles of latency → mm2_stall high 2 cycles (WAIT); wb_wdata=0xFFFF_FF80. Repeat with ld.bu → 0x0000_0080.
- ld.h, addr_l=2, rdata=0x8001_7FFF → 0xFFFF_8001; addr_l=0 → 0x0000_7FFF.
- Response arrives while wb_allowin=0 for 3 cycles → FULL; stall held; wb_* unchanged; retire on the first wb_allowin=1 with the buffered word.
- Flush in WAIT, response 4 cycles later, next load already in MM2 → DRAIN swallows the first response; the second response retires to the new load; the flushed instruction never appears on wb.
- Flush coincident with dm_rdata_valid in WAIT → IDLE, no retire; assert rst_n low mid-WAIT → wb_valid=0 and state IDLE immediately, without waiting for a clock edge.
